uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving the byte width passed to the UART transmitter.
REQ-002 The module SHALL have parameter DEPTH, default 16, giving the FIFO entry count; it is a power of two and at least 2.
REQ-003 The module SHALL have localparam ADDR_WIDTH = $clog2(DEPTH).
REQ-004 The module SHALL have port clk, input, 1 bit: the clock; all logic is on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port s_valid, input, 1 bit: the upstream byte is valid.
REQ-007 The module SHALL have port s_data, input, DATA_WIDTH bits: the upstream byte.
REQ-008 The module SHALL have port s_ready, output, 1 bit: the FIFO accepts a byte this cycle.
REQ-009 The module SHALL have port tx_enable, output, 1 bit: a one-cycle launch pulse to the UART Tx enable input.
REQ-010 The module SHALL have port tx_data, output, DATA_WIDTH bits: the byte driven to the UART Tx i_data input.
REQ-011 The module SHALL have port tx_busy, input, 1 bit: the UART Tx o_busy.
REQ-012 The module SHALL have port full, output, 1 bit: the FIFO holds DEPTH entries.
REQ-013 The module SHALL have port empty, output, 1 bit: the FIFO holds 0 entries.
REQ-014 The module SHALL have port level, output, ADDR_WIDTH+1 bits: the current entry count; this port exists only under UART_TX_FIFO_LEVEL_EN.

Function
REQ-015 Storage SHALL be a DEPTH-entry circular buffer with read and write pointers of ADDR_WIDTH+1 bits (wrap bit included); full = MSBs differ and the low bits are equal; empty = pointers equal.
REQ-016 s_ready SHALL equal !full, derived from registered state only, with no combinational path from any input.
REQ-017 A push SHALL occur when s_valid && s_ready; when full, s_valid SHALL be ignored, with no data change and no pointer change.
REQ-018 The dispatcher FSM SHALL have the states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-019 In IDLE, when !empty && !tx_busy, the FSM SHALL pop the head entry into the tx_data register, advance the read pointer, and go to LAUNCH; otherwise it SHALL stay in IDLE.
REQ-020 In LAUNCH, tx_enable SHALL be 1 for exactly this cycle, and the FSM SHALL then go to WAIT_BUSY.
REQ-021 In WAIT_BUSY, the FSM SHALL go to WAIT_DONE when tx_busy = 1 and SHALL otherwise stay in WAIT_BUSY.
REQ-022 In WAIT_DONE, the FSM SHALL go to IDLE when tx_busy = 0.
REQ-023 tx_data SHALL be registered and SHALL stay constant from the pop cycle until the FSM next re-enters IDLE, so i_data is stable for the whole UART frame.
REQ-024 tx_enable SHALL be 0 in every state except LAUNCH, and SHALL never be 1 while tx_busy = 1.
REQ-025 When a push and a pop happen in the same cycle, both SHALL take effect and the count SHALL be unchanged.
REQ-026 A pop SHALL never occur when the FIFO is empty.
REQ-027 Latency: a byte pushed at cycle N into an empty FIFO with the FSM in IDLE and tx_busy = 0 SHALL give tx_enable = 1 at cycle N+2, with tx_data equal to that byte.
REQ-028 Ordering SHALL be strict FIFO, with no drop or duplication across pointer wrap-around.
REQ-029 Throughput SHALL be at most one byte per UART frame, with the next launch no earlier than 2 cycles after tx_busy falls.

Reset
REQ-030 On reset = 1 at a clock edge, the module SHALL set both pointers to 0, the FSM to IDLE, tx_enable to 0 and tx_data to 0; resulting outputs: s_ready = 1, empty = 1, full = 0, level = 0.
REQ-031 A reset mid-operation, in any state, SHALL discard all stored bytes and any in-flight byte, with no tx_enable in the cycle after reset.
REQ-032 Storage array contents SHALL not be reset.

Configuration
REQ-033 With macro UART_TX_FIFO_LEVEL_EN defined, the level port SHALL exist and SHALL equal write pointer minus read pointer, registered with the pointers, with a range of 0..DEPTH.
REQ-034 Without UART_TX_FIFO_LEVEL_EN, the level port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 Bench SHALL cover: reset, then push 0xA5 at cycle N with tx_busy = 0 -> tx_enable pulse at N+2 with tx_data = 0xA5; empty = 1 from N+2 onward.
REQ-036 Bench SHALL cover: push 16 bytes 0x00..0x0F back-to-back while tx_busy is held at 1 -> full = 1 after the 16th push, s_ready = 0, a 17th push (0xFF) is ignored, and level = 16 when the macro is defined.
REQ-037 Bench SHALL cover: looped-back UART model (busy for 11 bit-times) with 40 bytes pushed -> 40 tx_enable pulses, in order, each while tx_busy = 0, tx_data stable through each frame, pointers wrapping twice.
REQ-038 Bench SHALL cover: with the FIFO at level 5, push and pop in the same cycle -> level stays 5, and the pushed byte comes out sixth.
REQ-039 Bench SHALL cover: reset asserted in WAIT_DONE with 3 bytes queued -> next cycle empty = 1, FSM IDLE, tx_enable = 0, tx_data = 0, and no launch while no new push arrives.
REQ-040 Bench SHALL cover: tx_busy held at 0 after LAUNCH -> FSM stays in WAIT_BUSY, and no second tx_enable occurs.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that launches one UART Tx frame at a time.
// Define UART_TX_FIFO_LEVEL_EN to expose the occupancy count on level.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  tx_enable,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_busy,
    output logic                  full,
    output logic                  empty
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level
`endif
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LAUNCH    = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  push;
    logic                  pop;

    // Wrap bit distinguishes full from empty when the low bits match.
    assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign s_ready   = !full;
    assign push      = s_valid && !full;
    assign pop       = (state == IDLE) && !empty && !tx_busy;
    assign tx_enable = (state == LAUNCH);

`ifdef UART_TX_FIFO_LEVEL_EN
    assign level = wr_ptr - rd_ptr;
`endif

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (pop) state_next = LAUNCH;
            end
            LAUNCH: begin
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!tx_busy) state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tx_data <= '0;
        end else begin
            state <= state_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                tx_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[ADDR_WIDTH-1:0]] <= s_data;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo with a looped UART model.
// Outputs are sampled on the falling edge; inputs change just after it.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready;
    logic       tx_enable;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       full;
    logic       empty;
`ifdef UART_TX_FIFO_LEVEL_EN
    logic [4:0] level;
`endif

    logic       model_en = 1'b0;
    logic       model_busy = 1'b0;
    logic       busy_force = 1'b0;
    int         model_cnt = 0;
    logic       prev_busy = 1'b0;
    logic       frame_act = 1'b0;
    logic [7:0] cur_byte = 8'h00;
    int         launches = 0;
    int         nvec = 0;
    int         nerr = 0;
    logic [7:0] exp_q[$];

    assign tx_busy = model_en ? model_busy : busy_force;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
        .clk(clk),
        .reset(reset),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .tx_enable(tx_enable),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .full(full),
        .empty(empty)
`ifdef UART_TX_FIFO_LEVEL_EN
        ,
        .level(level)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        s_valid = 1'b0;
        exp_q.delete();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        bit done = 0;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !frame_act) begin
                done = 1;
                break;
            end
            step();
        end
        check("drain_timeout", done, 1);
        step();
        step();
    endtask

    // Scoreboard and UART model: busy rises the cycle after enable, 44 cycles.
    always @(negedge clk) begin
        if (reset) begin
            frame_act = 1'b0;
            model_cnt = 0;
            model_busy = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (frame_act) check("tx_stable", tx_data, cur_byte);
            if (frame_act && prev_busy && !tx_busy) frame_act = 1'b0;
            if (tx_enable) begin
                launches++;
                check("en_while_busy", tx_busy, 0);
                if (exp_q.size() == 0) check("spurious_en", 1, 0);
                else check("tx_order", tx_data, exp_q.pop_front());
                frame_act = 1'b1;
                cur_byte = tx_data;
            end
            prev_busy = tx_busy;
            if (model_en) begin
                if (tx_enable) model_cnt = 45;
                else if (model_cnt > 0) model_cnt--;
                model_busy = (model_cnt >= 1) && (model_cnt <= 44);
            end
        end
    end

    initial begin
        int sent;
        int l0;
        bit seen;

        step();
        do_reset();
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ready", s_ready, 1);
        check("rst_en", tx_enable, 0);
        check("rst_data", tx_data, 0);
`ifdef UART_TX_FIFO_LEVEL_EN
        check("rst_level", level, 0);
`endif

        // Single byte latency: push at N, launch at N+2.
        busy_force = 1'b0;
        s_valid = 1'b1;
        s_data = 8'hA5;
        if (s_ready) exp_q.push_back(8'hA5);
        step();
        s_valid = 1'b0;
        check("lat_n1_en", tx_enable, 0);
        step();
        check("lat_n2_en", tx_enable, 1);
        check("lat_n2_data", tx_data, 8'hA5);
        check("lat_n2_empty", empty, 1);

        // Busy never rises: no further launch even with data queued.
        s_valid = 1'b1;
        s_data = 8'h5A;
        exp_q.push_back(8'h5A);
        step();
        s_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("stuck_no_en", tx_enable, 0);
            step();
        end
        check("stuck_not_empty", empty, 0);
        busy_force = 1'b1;
        step();
        step();
        busy_force = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (tx_enable) seen = 1;
        end
        check("resume_launch", seen, 1);

        // Fill to full while the transmitter is busy.
        do_reset();
        busy_force = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data = 8'(i);
            check("fill_ready", s_ready, 1);
            exp_q.push_back(8'(i));
            step();
        end
        s_data = 8'hFF;
        check("full_flag", full, 1);
        check("full_ready", s_ready, 0);
`ifdef UART_TX_FIFO_LEVEL_EN
        check("full_level", level, 16);
`endif
        step();
        s_valid = 1'b0;
        check("full_hold", full, 1);
`ifdef UART_TX_FIFO_LEVEL_EN
        check("full_hold_level", level, 16);
`endif
        model_en = 1'b1;
        wait_drain(2000);
        check("drained_empty", empty, 1);

        // Same-cycle push and pop at level 5.
        model_en = 1'b0;
        busy_force = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data = 8'hB0 + 8'(i);
            exp_q.push_back(8'hB0 + 8'(i));
            step();
        end
        s_valid = 1'b0;
`ifdef UART_TX_FIFO_LEVEL_EN
        check("lvl5_before", level, 5);
`endif
        check("lvl5_not_empty", empty, 0);
        model_en = 1'b1;
        s_valid = 1'b1;
        s_data = 8'h77;
        exp_q.push_back(8'h77);
        step();
        s_valid = 1'b0;
        check("pp_launch", tx_enable, 1);
`ifdef UART_TX_FIFO_LEVEL_EN
        check("pp_level", level, 5);
`endif
        wait_drain(2000);

        // 40 bytes through the looped-back UART, wrapping the pointers.
        l0 = launches;
        sent = 0;
        for (int c = 0; c < 5000 && sent < 40; c++) begin
            s_valid = 1'b1;
            s_data = 8'(sent * 7 + 3);
            if (s_ready) begin
                exp_q.push_back(8'(sent * 7 + 3));
                sent++;
            end
            step();
        end
        s_valid = 1'b0;
        check("stream_sent", sent, 40);
        wait_drain(3000);
        check("stream_launches", launches - l0, 40);

        // Reset while in WAIT_DONE with three bytes queued.
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data = 8'hC0 + 8'(i);
            exp_q.push_back(8'hC0 + 8'(i));
            step();
        end
        s_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (tx_busy) seen = 1;
            else step();
        end
        check("wd_busy_seen", seen, 1);
        step();
        check("wd_queued", empty, 0);
        model_en = 1'b0;
        busy_force = 1'b0;
        do_reset();
        check("wd_rst_empty", empty, 1);
        check("wd_rst_en", tx_enable, 0);
        check("wd_rst_data", tx_data, 0);
`ifdef UART_TX_FIFO_LEVEL_EN
        check("wd_rst_level", level, 0);
`endif
        for (int i = 0; i < 10; i++) begin
            step();
            check("wd_no_launch", tx_enable, 0);
        end
        s_valid = 1'b1;
        s_data = 8'h3C;
        exp_q.push_back(8'h3C);
        step();
        s_valid = 1'b0;
        check("wd_idle_n1", tx_enable, 0);
        step();
        check("wd_idle_n2", tx_enable, 1);
        check("wd_idle_data", tx_data, 8'h3C);
        step();
        check("wd_leftover", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
